// File: rtl/pio_wmem_app_arb.sv
// ---------------------------------------------------------------------------
// pio_wmem_app_arb
//
// Purpose:
//   Arbitrates two clients (a, b) onto one wide memory that has separate read
//   and write command ports. Read and write arbitration are independent
//   round-robin arbiters. Memory commands are issued from registers one cycle
//   after the grant. Read data returns 3 cycles after app_mem_rd and is routed
//   back to its owner using a small ownership shift register.
//
// Configuration:
//   WMEM_INIT_SWEEP_EN - when defined, the block writes zero to every memory
//                        word (address 0..2^DEPTH_NBITS-1, one per cycle) after
//                        reset before accepting client traffic. When undefined,
//                        the block accepts client traffic one cycle after reset.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   x_rd_req / x_raddr           read request and address from client x
//   x_rd_gnt                     read request accepted this cycle
//   x_rd_ack / x_rdata           read data valid / read data for client x
//   x_wr_req / x_waddr / x_wdata write request, address and data from client x
//   x_wr_gnt                     write request accepted this cycle
//   app_mem_rd / app_mem_raddr   read command to the memory
//   app_mem_wr / app_mem_waddr / app_mem_wdata   write command to the memory
//   app_mem_ack / app_mem_rdata  read return from the memory
//   init_done                    memory is usable by clients
// ---------------------------------------------------------------------------
module pio_wmem_app_arb #(
  parameter int WIDTH       = 40,
  parameter int DEPTH_NBITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   a_rd_req,
  input  logic [DEPTH_NBITS-1:0] a_raddr,
  output logic                   a_rd_gnt,
  output logic                   a_rd_ack,
  output logic [WIDTH-1:0]       a_rdata,
  input  logic                   a_wr_req,
  input  logic [DEPTH_NBITS-1:0] a_waddr,
  input  logic [WIDTH-1:0]       a_wdata,
  output logic                   a_wr_gnt,

  input  logic                   b_rd_req,
  input  logic [DEPTH_NBITS-1:0] b_raddr,
  output logic                   b_rd_gnt,
  output logic                   b_rd_ack,
  output logic [WIDTH-1:0]       b_rdata,
  input  logic                   b_wr_req,
  input  logic [DEPTH_NBITS-1:0] b_waddr,
  input  logic [WIDTH-1:0]       b_wdata,
  output logic                   b_wr_gnt,

  output logic                   app_mem_rd,
  output logic [DEPTH_NBITS-1:0] app_mem_raddr,
  output logic                   app_mem_wr,
  output logic [DEPTH_NBITS-1:0] app_mem_waddr,
  output logic [WIDTH-1:0]       app_mem_wdata,
  input  logic                   app_mem_ack,
  input  logic [WIDTH-1:0]       app_mem_rdata,

  output logic                   init_done
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   rd_last_b_q, rd_last_b_d;   // last read winner was b
  logic                   wr_last_b_q, wr_last_b_d;   // last write winner was b
  logic                   mem_rd_q, mem_rd_d;
  logic [DEPTH_NBITS-1:0] mem_raddr_q, mem_raddr_d;
  logic                   rd_own_b_q, rd_own_b_d;     // owner of the read on app_mem_rd
  logic                   mem_wr_q, mem_wr_d;
  logic [DEPTH_NBITS-1:0] mem_waddr_q, mem_waddr_d;
  logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  // Ownership pipeline: index 0 is one cycle after app_mem_rd, index 2 lines
  // up with the cycle app_mem_ack returns for that read.
  logic [2:0]             own_v_q, own_v_d;
  logic [2:0]             own_b_q, own_b_d;
`ifdef WMEM_INIT_SWEEP_EN
  // One extra bit so the counter can reach 2^DEPTH_NBITS and stop there
  // instead of wrapping back to address 0.
  logic [DEPTH_NBITS:0]   cnt_q, cnt_d;
`endif

  logic run;

  // Grants are only possible in RUN and never while reset is asserted.
  assign run = (state_q == ST_RUN) && !rst;

  // Round-robin: on conflict the client that did not win last time wins.
  assign a_rd_gnt = run && a_rd_req && (!b_rd_req ||  rd_last_b_q);
  assign b_rd_gnt = run && b_rd_req && (!a_rd_req || !rd_last_b_q);
  assign a_wr_gnt = run && a_wr_req && (!b_wr_req ||  wr_last_b_q);
  assign b_wr_gnt = run && b_wr_req && (!a_wr_req || !wr_last_b_q);

  // Acks that arrive with no tracked read in stage 2 are dropped.
  assign a_rd_ack = !rst && app_mem_ack && own_v_q[2] && !own_b_q[2];
  assign b_rd_ack = !rst && app_mem_ack && own_v_q[2] &&  own_b_q[2];
  assign a_rdata  = app_mem_rdata;
  assign b_rdata  = app_mem_rdata;

  assign app_mem_rd    = mem_rd_q;
  assign app_mem_raddr = mem_raddr_q;
  assign app_mem_wr    = mem_wr_q;
  assign app_mem_waddr = mem_waddr_q;
  assign app_mem_wdata = mem_wdata_q;
  assign init_done     = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    rd_last_b_d = rd_last_b_q;
    wr_last_b_d = wr_last_b_q;
    mem_rd_d    = 1'b0;
    mem_raddr_d = mem_raddr_q;
    rd_own_b_d  = rd_own_b_q;
    mem_wr_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    own_v_d     = {own_v_q[1:0], mem_rd_q};
    own_b_d     = {own_b_q[1:0], rd_own_b_q};
`ifdef WMEM_INIT_SWEEP_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ST_INIT: begin
`ifdef WMEM_INIT_SWEEP_EN
        if (cnt_q[DEPTH_NBITS]) begin
          // Last word was presented in the previous cycle.
          state_d = ST_RUN;
        end else begin
          mem_wr_d    = 1'b1;
          mem_waddr_d = cnt_q[DEPTH_NBITS-1:0];
          mem_wdata_d = '0;
          cnt_d       = cnt_q + {{DEPTH_NBITS{1'b0}}, 1'b1};
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (a_rd_gnt || b_rd_gnt) begin
          mem_rd_d    = 1'b1;
          mem_raddr_d = b_rd_gnt ? b_raddr : a_raddr;
          rd_own_b_d  = b_rd_gnt;
          rd_last_b_d = b_rd_gnt;
        end
        if (a_wr_gnt || b_wr_gnt) begin
          mem_wr_d    = 1'b1;
          mem_waddr_d = b_wr_gnt ? b_waddr : a_waddr;
          mem_wdata_d = b_wr_gnt ? b_wdata : a_wdata;
          wr_last_b_d = b_wr_gnt;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      rd_last_b_q <= 1'b1;
      wr_last_b_q <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_raddr_q <= '0;
      rd_own_b_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      own_v_q     <= '0;
      own_b_q     <= '0;
`ifdef WMEM_INIT_SWEEP_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_last_b_q <= rd_last_b_d;
      wr_last_b_q <= wr_last_b_d;
      mem_rd_q    <= mem_rd_d;
      mem_raddr_q <= mem_raddr_d;
      rd_own_b_q  <= rd_own_b_d;
      mem_wr_q    <= mem_wr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      own_v_q     <= own_v_d;
      own_b_q     <= own_b_d;
`ifdef WMEM_INIT_SWEEP_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pio_wmem_app_arb.sv
// ---------------------------------------------------------------------------
// tb_pio_wmem_app_arb
//
// Bench for pio_wmem_app_arb (WIDTH=16, DEPTH_NBITS=4). A memory model with a
// fixed 3-cycle read return sits on the app_mem_* side. A transaction-level
// reference (round-robin winners, shadow memory, queue of expected read
// returns) predicts grants, memory commands and client acks every cycle.
// Handles both builds of WMEM_INIT_SWEEP_EN.
// ---------------------------------------------------------------------------
module tb_pio_wmem_app_arb;
  localparam int W  = 16;
  localparam int DN = 4;
  localparam int NW = 1 << DN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_rd_req, b_rd_req, a_wr_req, b_wr_req;
  logic [DN-1:0] a_raddr, b_raddr, a_waddr, b_waddr;
  logic [W-1:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  logic          a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt, a_rd_ack, b_rd_ack;
  logic          app_mem_rd, app_mem_wr, app_mem_ack, init_done;
  logic [DN-1:0] app_mem_raddr, app_mem_waddr;
  logic [W-1:0]  app_mem_wdata, app_mem_rdata;

  pio_wmem_app_arb #(.WIDTH(W), .DEPTH_NBITS(DN)) dut (
    .clk(clk), .rst(rst),
    .a_rd_req(a_rd_req), .a_raddr(a_raddr), .a_rd_gnt(a_rd_gnt),
    .a_rd_ack(a_rd_ack), .a_rdata(a_rdata),
    .a_wr_req(a_wr_req), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_wr_gnt(a_wr_gnt),
    .b_rd_req(b_rd_req), .b_raddr(b_raddr), .b_rd_gnt(b_rd_gnt),
    .b_rd_ack(b_rd_ack), .b_rdata(b_rdata),
    .b_wr_req(b_wr_req), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_wr_gnt(b_wr_gnt),
    .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
    .app_mem_wr(app_mem_wr), .app_mem_waddr(app_mem_waddr), .app_mem_wdata(app_mem_wdata),
    .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
    .init_done(init_done)
  );

  // ---------------- memory environment (3-cycle read return) --------------
  logic [W-1:0] env_mem [NW];
  logic         p1_v = 1'b0, p2_v = 1'b0, p3_v = 1'b0;
  logic [W-1:0] p1_d = '0, p2_d = '0, p3_d = '0;
  logic         stray = 1'b0;

  always @(posedge clk) begin
    p1_v <= app_mem_rd;
    p1_d <= env_mem[app_mem_raddr];
    p2_v <= p1_v;  p2_d <= p1_d;
    p3_v <= p2_v;  p3_d <= p2_d;
    if (app_mem_wr) env_mem[app_mem_waddr] <= app_mem_wdata;
  end
  assign app_mem_ack   = p3_v | stray;
  assign app_mem_rdata = p3_d;

  // ---------------- checking ----------------------------------------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ---------------------------------------
  typedef struct {
    int           due;
    bit           cl_b;
    logic [W-1:0] data;
  } pend_t;

  pend_t         pend[$];
  logic [W-1:0]  shadow [NW];
  bit            m_rd_last_b, m_wr_last_b;
  bit            e_rd, e_wr;
  logic [DN-1:0] e_raddr, e_waddr;
  logic [W-1:0]  e_wdata;
  int            cyc = 0;

  task automatic model_reset();
    m_rd_last_b = 1'b1;
    m_wr_last_b = 1'b1;
    pend.delete();
    e_rd = 1'b0;
    e_wr = 1'b0;
`ifdef WMEM_INIT_SWEEP_EN
    for (int i = 0; i < NW; i++) shadow[i] = '0;
`endif
  endtask

  // One RUN cycle: drive requests, compare everything against the model,
  // advance the model, move to the next negedge. g returns the DUT grants
  // as {a_rd, b_rd, a_wr, b_wr}.
  task automatic step(input bit ar, input bit br, input bit aw, input bit bw,
                      input logic [DN-1:0] ara, input logic [DN-1:0] bra,
                      input logic [DN-1:0] awa, input logic [DN-1:0] bwa,
                      input logic [W-1:0] awd, input logic [W-1:0] bwd,
                      output logic [3:0] g);
    bit eag, ebg, eaw, ebw, ea_ack, eb_ack;
    logic [W-1:0] ed;
    a_rd_req = ar; b_rd_req = br; a_wr_req = aw; b_wr_req = bw;
    a_raddr = ara; b_raddr = bra; a_waddr = awa; b_waddr = bwa;
    a_wdata = awd; b_wdata = bwd;
    #1;
    eag = ar && (!br || m_rd_last_b);
    ebg = br && (!ar || !m_rd_last_b);
    eaw = aw && (!bw || m_wr_last_b);
    ebw = bw && (!aw || !m_wr_last_b);
    g = {a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt};
    chk("gnt", g, {eag, ebg, eaw, ebw});
    chk("mem_rd", app_mem_rd, e_rd);
    if (e_rd) chk("mem_raddr", app_mem_raddr, e_raddr);
    chk("mem_wr", app_mem_wr, e_wr);
    if (e_wr) begin
      chk("mem_waddr", app_mem_waddr, e_waddr);
      chk("mem_wdata", app_mem_wdata, e_wdata);
    end
    ea_ack = 1'b0; eb_ack = 1'b0; ed = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ea_ack = !pend[0].cl_b;
      eb_ack = pend[0].cl_b;
      ed = pend[0].data;
      void'(pend.pop_front());
    end
    chk("rd_ack", {a_rd_ack, b_rd_ack}, {ea_ack, eb_ack});
    if (ea_ack) chk("a_rdata", a_rdata, ed);
    if (eb_ack) chk("b_rdata", b_rdata, ed);
    // Advance: read captures memory before this cycle's write lands.
    e_rd = eag || ebg;
    if (e_rd) begin
      e_raddr = ebg ? bra : ara;
      pend.push_back('{due: cyc + 4, cl_b: ebg, data: shadow[e_raddr]});
      m_rd_last_b = ebg;
    end
    e_wr = eaw || ebw;
    if (e_wr) begin
      e_waddr = ebw ? bwa : awa;
      e_wdata = ebw ? bwd : awd;
      shadow[e_waddr] = e_wdata;
      m_wr_last_b = ebw;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [3:0] g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  // Reset for n edges with all requests high, then bring the block up.
  task automatic do_reset(input int n);
    rst = 1'b1; stray = 1'b0;
    a_rd_req = 1; b_rd_req = 1; a_wr_req = 1; b_wr_req = 1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("rst_gnt", {a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt}, 4'b0);
      chk("rst_ack", {a_rd_ack, b_rd_ack}, 2'b0);
      @(negedge clk);
    end
    #1;
    chk("rst_mem_cmd", {app_mem_rd, app_mem_wr}, 2'b0);
    chk("rst_init_done", init_done, 1'b0);
    rst = 1'b0;
    model_reset();
`ifdef WMEM_INIT_SWEEP_EN
    for (int k = 0; k < NW; k++) begin
      @(negedge clk); #1;
      chk("sweep_gnt", {a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt}, 4'b0);
      chk("sweep_wr", {app_mem_wr, app_mem_rd, init_done}, 3'b100);
      chk("sweep_waddr", app_mem_waddr, k);
      chk("sweep_wdata", app_mem_wdata, 0);
      chk("sweep_ack", {a_rd_ack, b_rd_ack}, 2'b0);
    end
`else
    a_rd_req = 0; b_rd_req = 0; a_wr_req = 0; b_wr_req = 0;
`endif
    @(negedge clk); #1;
    chk("init_done", init_done, 1'b1);
    chk("up_mem_cmd", {app_mem_rd, app_mem_wr}, 2'b0);
    chk("up_ack", {a_rd_ack, b_rd_ack}, 2'b0);
  endtask

  // ---------------- stimulus ----------------------------------------------
  typedef struct {
    bit         ar, br, aw, bw;
    logic [3:0] exp;   // {a_rd, b_rd, a_wr, b_wr} grants
  } vec_t;

  initial begin
    vec_t tbl[8];
    logic [3:0] g;
    tbl[0] = '{1, 1, 1, 1, 4'b1010};
    tbl[1] = '{1, 1, 0, 0, 4'b0100};
    tbl[2] = '{1, 0, 0, 1, 4'b1001};
    tbl[3] = '{1, 1, 1, 1, 4'b0110};
    tbl[4] = '{0, 0, 1, 1, 4'b0001};
    tbl[5] = '{0, 1, 1, 0, 4'b0110};
    tbl[6] = '{1, 1, 1, 1, 4'b1001};
    tbl[7] = '{0, 0, 0, 0, 4'b0000};

    for (int i = 0; i < NW; i++) begin
      env_mem[i] = '0;
      shadow[i]  = '0;
    end
    rst = 1'b1;
    a_rd_req = 0; b_rd_req = 0; a_wr_req = 0; b_wr_req = 0;
    a_raddr = 0; b_raddr = 0; a_waddr = 0; b_waddr = 0; a_wdata = 0; b_wdata = 0;
    @(negedge clk);
    do_reset(2);

    // Round-robin table, starting from the reset pointer (a wins first).
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].ar, tbl[i].br, tbl[i].aw, tbl[i].bw,
           DN'(i), DN'(i + 8), DN'(i), DN'(15 - i),
           W'($urandom), W'($urandom), g);
      chk($sformatf("tbl%0d_gnt", i), g, tbl[i].exp);
    end
    idle(5);

    // Both clients reading continuously: strict alternation a,b,a,...
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 0, 0, 3, 5, 0, 0, 0, 0, g);
      chk("alt_gnt", g[3:2], (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    idle(5);

    // Write then read the same address: read sees the new data.
    step(0, 0, 1, 0, 0, 0, 7, 0, 16'h00AB, 0, g);
    step(1, 0, 0, 0, 7, 0, 0, 0, 0, 0, g);
    idle(5);

    // Same-cycle read and write to one address: read returns old data.
    step(0, 1, 1, 0, 0, 9, 9, 0, 16'h1234, 0, g);
    step(1, 0, 0, 1, 9, 0, 0, 9, 0, 16'h5678, g);
    idle(5);

    // Stray ack with nothing in flight.
    stray = 1'b1;
    idle(1);
    stray = 1'b0;

    // Reset one cycle after a read grant: its returning ack must be dropped.
    step(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, g);
    do_reset(1);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           DN'($urandom), DN'($urandom), DN'($urandom), DN'($urandom),
           W'($urandom), W'($urandom), g);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_wmem_app_arb.md
PIO_WMEM_APP_ARB -- requirements
Module: pio_wmem_app_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 40, the memory word width in bits.
REQ-002 SHALL have parameter DEPTH_NBITS, default 10, the memory address width (2^DEPTH_NBITS words).
REQ-003 SHALL have port clk, in, 1, the single clock.
REQ-004 SHALL have port rst, in, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports x_rd_req, in, 1, read request from client x, for x in {a,b}.
REQ-006 SHALL have ports x_raddr, in, DEPTH_NBITS, read address from client x.
REQ-007 SHALL have ports x_rd_gnt, out, 1, read request accepted this cycle.
REQ-008 SHALL have ports x_rd_ack, out, 1, read data valid for client x.
REQ-009 SHALL have ports x_rdata, out, WIDTH, read data for client x.
REQ-010 SHALL have ports x_wr_req, in, 1, write request from client x.
REQ-011 SHALL have ports x_waddr, in, DEPTH_NBITS, write address from client x.
REQ-012 SHALL have ports x_wdata, in, WIDTH, write data from client x.
REQ-013 SHALL have ports x_wr_gnt, out, 1, write request accepted this cycle.
REQ-014 SHALL have ports app_mem_rd, out, 1, and app_mem_raddr, out, DEPTH_NBITS, the read command to the wide memory.
REQ-015 SHALL have ports app_mem_wr, out, 1; app_mem_waddr, out, DEPTH_NBITS; app_mem_wdata, out, WIDTH, the write command to the wide memory.
REQ-016 SHALL have ports app_mem_ack, in, 1, and app_mem_rdata, in, WIDTH, the read return from the wide memory.
REQ-017 SHALL have port init_done, out, 1, high once the memory is usable by clients.

Function
REQ-018 Read and write arbitration SHALL be independent; each SHALL grant at most one client per cycle.
REQ-019 Grants SHALL be combinational from requests and state; a request is consumed in the cycle its gnt is high; gnt SHALL be 0 when init_done=0.
REQ-020 Each arbiter SHALL be round-robin: one requester -> grant it; both -> grant the client not granted last by that arbiter; last-winner pointer resets to b (a wins first conflict).
REQ-021 A grant at cycle T SHALL drive the corresponding app_mem_rd/raddr or app_mem_wr/waddr/wdata from registers at T+1; with no grant, app_mem_rd/app_mem_wr SHALL be 0 at T+1.
REQ-022 The memory returns app_mem_ack exactly 3 cycles after app_mem_rd; the block SHALL track ownership in a 3-stage shift register aligned to app_mem_rd, one stage per cycle, back-to-back reads every cycle supported.
REQ-023 x_rd_ack SHALL equal app_mem_ack AND (owner stage 3 == x); x_rdata SHALL equal app_mem_rdata combinationally; total read latency gnt->ack = 4 cycles.
REQ-024 app_mem_ack with no tracked read SHALL be ignored (no client ack).
REQ-025 Read and write to the same address in the same cycle: no forwarding; read returns memory behaviour (old data); block SHALL NOT reorder.
REQ-026 State machine: INIT -> RUN; INIT sweeps, RUN arbitrates; RUN is terminal until rst.
REQ-027 In INIT the block SHALL drive app_mem_wr=1, app_mem_wdata=0, app_mem_waddr = counter 0..2^DEPTH_NBITS-1, one word per cycle; app_mem_rd=0.
REQ-028 On the cycle after address 2^DEPTH_NBITS-1 is written, state SHALL be RUN and init_done=1; counter SHALL NOT wrap.

Reset
REQ-029 rst SHALL clear app_mem_rd, app_mem_wr, ownership stages, and set app_mem_raddr/waddr/wdata=0, init counter=0, state=INIT, init_done=0, pointers to b.
REQ-030 rst asserted mid-sweep or with reads in flight SHALL restart the sweep at address 0 and discard in-flight ownership; acks returning after rst SHALL be dropped.
REQ-031 All gnt/ack outputs SHALL be 0 while rst is high.

Configuration
REQ-032 Macro WMEM_INIT_SWEEP_EN: defined -> INIT sweep per REQ-027/028.
REQ-033 Undefined -> no sweep; state SHALL enter RUN on the first cycle after rst deasserts, init_done=1 from that cycle, app_mem_wr never driven by the block except by client grants.

Verification
REQ-034 Reset release, macro defined, DEPTH_NBITS=4 -> 16 writes of 0 to addr 0..15, init_done=1 on cycle 17, no gnt before.
REQ-035 a_rd_req and b_rd_req held high, a_raddr=3, b_raddr=5 -> gnts alternate a,b,a,...; app_mem_raddr 3,5,3; a_rd_ack/b_rd_ack alternate 4 cycles after each gnt.
REQ-036 a_wr_req addr 7 data 0xAB at T, a_rd_req addr 7 at T+1 -> app_mem_wr at T+1, app_mem_rd at T+2, a_rd_ack at T+5 with a_rdata=0xAB.
REQ-037 a_rd_req granted, rst pulsed 1 cycle later -> no a_rd_ack; app_mem_ack injected at expected time produces no client ack; sweep restarts at 0.
REQ-038 Stray app_mem_ack with no reads issued -> a_rd_ack=b_rd_ack=0.
REQ-039 Macro undefined -> init_done=1 first cycle after rst; simultaneous a_wr_req/b_wr_req -> a granted first, then b.
